link10_mm_bridge: RTL
=====================

Name: link10_mm_bridge

Overview:
- Upstream stage of the link10 register address decoder; converts a host-side Avalon-MM slave port into the single-cycle pulse register bus the decoder consumes (MM_WR_EN / MM_RD_EN / MM_ADDR / MM_WR_DATA, RD_DATA / RD_DATA_V).
- Holds the host with waitrequest while a transaction is in flight.
- Enforces one outstanding read and times out if no read response returns, so a dead decode can never hang the host.

Parameters:
- TIMEOUT, 64, cycles spent in RD_WAIT before a synthetic response is returned; legal range 2..65535.
- TO_PATTERN, 32'hDEAD_BEEF, upper 32 bits of the timeout read data.

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- avs_address  in  17  host word address
- avs_read  in  1  host read request
- avs_write  in  1  host write request
- avs_writedata  in  64  host write data
- avs_waitrequest  out  1  host stall
- avs_readdata  out  64  read return data
- avs_readdatavalid  out  1  read return strobe, one cycle
- oMM_ADDR  out  17  address to decoder
- oMM_WR_DATA  out  64  write data to decoder
- oMM_WR_EN  out  1  write pulse to decoder
- oMM_RD_EN  out  1  read pulse to decoder
- iMM_RD_DATA  in  64  read data from decoder
- iMM_RD_DATA_V  in  1  read data valid from decoder
- o_timeout  out  1  one-cycle pulse when a read times out
- o_proto_err  out  1  one-cycle pulse on simultaneous read and write

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - oMM_WR_EN, oMM_RD_EN, avs_readdatavalid, o_timeout, o_proto_err = 0.
  - oMM_ADDR, oMM_WR_DATA, avs_readdata = 0.
  - Counter = 0.
  - avs_waitrequest = 1 while rst is high.
- avs_waitrequest = rst | (state != IDLE). It is combinational from registered state only, with no path from avs_read or avs_write.
- States: IDLE, WR_PULSE, RD_ISSUE, RD_WAIT.
- IDLE + avs_write (accept cycle T):
  - Latch avs_address and avs_writedata into oMM_ADDR and oMM_WR_DATA.
  - Go to WR_PULSE. oMM_WR_EN = 1 during cycle T+1 only.
  - Return to IDLE. Maximum write rate is one per 2 cycles.
- IDLE + avs_read (accept cycle T):
  - Latch the address and go to RD_ISSUE. oMM_RD_EN = 1 during cycle T+1 only.
  - Go to RD_WAIT with counter cleared to 0.
- IDLE + avs_read + avs_write in the same cycle:
  - The write is performed and the read is dropped.
  - o_proto_err pulses at T+1.
- RD_WAIT:
  - Counter increments each cycle, 16 bits wide, compared to TIMEOUT-1.
  - If iMM_RD_DATA_V = 1:
    - Register iMM_RD_DATA into avs_readdata.
    - avs_readdatavalid = 1 on the next cycle.
    - Go to IDLE.
  - Else, if counter == TIMEOUT-1:
    - avs_readdata = {TO_PATTERN, 15'b0, oMM_ADDR}.
    - avs_readdatavalid = 1 and o_timeout = 1 on the next cycle.
    - Go to IDLE.
  - If valid arrives in the same cycle as the timeout, valid wins and there is no o_timeout.
- Read latency: avs_readdatavalid asserts exactly 1 cycle after iMM_RD_DATA_V. With a 3-cycle decoder, the host sees data at T+5.
- avs_readdata holds its value until the next read return. The write path never changes it.
- iMM_RD_DATA_V outside RD_WAIT is ignored; this includes a late response after a timeout. No output changes.
- oMM_ADDR and oMM_WR_DATA hold their last values between transactions.
- Reset mid-transaction aborts immediately:
  - No readdatavalid is ever produced for the aborted read.
  - Pulses de-assert asynchronously.

Optional Feature:
- Macro: LINK10_MM_TIMEOUT_CNT_EN.
- Defined:
  - Adds output o_timeout_cnt [15:0]: a saturating count of timeouts.
  - Cleared by rst. Holds at 16'hFFFF.
  - Increments in the same cycle o_timeout pulses.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Write: addr 17'h0_1234, data 64'h0123_4567_89AB_CDEF at T -> oMM_WR_EN=1 only at T+1 with those values; waitrequest high at T+1, low at T+2.
- Read with a 3-cycle responder: addr 17'h0_8010 at T, responder returns 64'hCAFE_F00D_0000_0001 -> oMM_RD_EN only at T+1; avs_readdatavalid=1 at T+5 with that data; exactly one strobe.
- Timeout: TIMEOUT=8, no responder, read addr 17'h1_0005 -> readdatavalid + o_timeout at T+10 with data 64'hDEAD_BEEF_0001_0005; a late iMM_RD_DATA_V at T+12 produces no strobe.
- Race: valid arrives exactly at counter==TIMEOUT-1 -> real data returned, o_timeout stays 0.
- Simultaneous avs_read=avs_write=1 -> one write pulse, no read pulse, o_proto_err=1 for one cycle.
- Assert rst during RD_WAIT, then release and issue a new read -> outputs zero immediately; only the new read's data is returned; with LINK10_MM_TIMEOUT_CNT_EN, count=0 after reset and 1 after one forced timeout.

Source files
------------

// File: rtl/link10_mm_bridge.sv
// Avalon-MM slave to single-cycle pulse register bus bridge for the link10 decoder.
// Optional LINK10_MM_TIMEOUT_CNT_EN adds a saturating timeout counter output.
module link10_mm_bridge #(
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [31:0] TO_PATTERN = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [63:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [63:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [16:0] oMM_ADDR,
    output logic [63:0] oMM_WR_DATA,
    output logic        oMM_WR_EN,
    output logic        oMM_RD_EN,
    input  logic [63:0] iMM_RD_DATA,
    input  logic        iMM_RD_DATA_V,
`ifdef LINK10_MM_TIMEOUT_CNT_EN
    output logic [15:0] o_timeout_cnt,
`endif
    output logic        o_timeout,
    output logic        o_proto_err
);

    typedef enum logic [1:0] {IDLE, WR_PULSE, RD_ISSUE, RD_WAIT} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [16:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        wr_en_q;
    logic        rd_en_q;
    logic        rdv_q;
    logic        to_q;
    logic        perr_q;
`ifdef LINK10_MM_TIMEOUT_CNT_EN
    logic [15:0] to_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            rdv_q    <= 1'b0;
            to_q     <= 1'b0;
            perr_q   <= 1'b0;
`ifdef LINK10_MM_TIMEOUT_CNT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            rdv_q   <= 1'b0;
            to_q    <= 1'b0;
            perr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A write wins over a simultaneous read; the read is dropped and flagged.
                    if (avs_write) begin
                        addr_q  <= avs_address;
                        wdata_q <= avs_writedata;
                        wr_en_q <= 1'b1;
                        perr_q  <= avs_read;
                        state_q <= WR_PULSE;
                    end else if (avs_read) begin
                        addr_q  <= avs_address;
                        rd_en_q <= 1'b1;
                        state_q <= RD_ISSUE;
                    end
                end
                WR_PULSE: state_q <= IDLE;
                RD_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (iMM_RD_DATA_V) begin
                        rdata_q <= iMM_RD_DATA;
                        rdv_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        rdata_q <= {TO_PATTERN, 15'b0, addr_q};
                        rdv_q   <= 1'b1;
                        to_q    <= 1'b1;
                        state_q <= IDLE;
`ifdef LINK10_MM_TIMEOUT_CNT_EN
                        if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avs_waitrequest   = rst | (state_q != IDLE);
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdv_q;
    assign oMM_ADDR          = addr_q;
    assign oMM_WR_DATA       = wdata_q;
    assign oMM_WR_EN         = wr_en_q;
    assign oMM_RD_EN         = rd_en_q;
    assign o_timeout         = to_q;
    assign o_proto_err       = perr_q;
`ifdef LINK10_MM_TIMEOUT_CNT_EN
    assign o_timeout_cnt     = to_cnt_q;
`endif

endmodule
